// File: rtl/oled_layer_sequencer.sv
// Layer compositor and raster tracker for the OLED pixel stream.
// Debounces layer-enable switches and latches them at frame start.
module oled_layer_sequencer #(
  parameter int          WIDTH           = 96,
  parameter int          HEIGHT          = 64,
  parameter int          NUM_LAYERS      = 4,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [15:0] TRANSPARENT     = 16'h0000,
  parameter logic [15:0] BG_COLOR        = 16'h0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_begin,
  input  logic                     sample_pixel,
  input  logic [12:0]              pixel_index,
  input  logic [NUM_LAYERS-1:0]    sw,
  input  logic [16*NUM_LAYERS-1:0] layer_pixel,
  output logic [6:0]               x,
  output logic [5:0]               y,
  output logic [15:0]              pixel_data,
  output logic [NUM_LAYERS-1:0]    layer_en,
  output logic [7:0]               frame_count,
  output logic                     sync_err
);

  localparam logic [6:0]  X_MAX  = 7'(WIDTH - 1);
  localparam logic [5:0]  Y_MAX  = 6'(HEIGHT - 1);
  localparam logic [15:0] DB_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [NUM_LAYERS-1:0] sw_s1;
  logic [NUM_LAYERS-1:0] sw_s2;
  logic [NUM_LAYERS-1:0] sw_deb;
  logic [15:0]           db_cnt [NUM_LAYERS];
  logic [12:0]           idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      sw_deb <= '0;
      for (int k = 0; k < NUM_LAYERS; k++)
        db_cnt[k] <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      for (int k = 0; k < NUM_LAYERS; k++) begin
        if (sw_s2[k] != sw_deb[k]) begin
          if (db_cnt[k] == DB_MAX) begin
            sw_deb[k] <= sw_s2[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + 16'd1;
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  // frame_begin wins over a coincident sample_pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x           <= '0;
      y           <= '0;
      idx         <= '0;
      frame_count <= '0;
      layer_en    <= '0;
    end else if (frame_begin) begin
      x           <= '0;
      y           <= '0;
      idx         <= '0;
      frame_count <= frame_count + 8'd1;
      layer_en    <= sw_deb;
    end else if (sample_pixel) begin
      if (x == X_MAX) begin
        x <= '0;
        if (y == Y_MAX) begin
          y   <= '0;
          idx <= '0;
        end else begin
          y   <= y + 6'd1;
          idx <= idx + 13'd1;
        end
      end else begin
        x   <= x + 7'd1;
        idx <= idx + 13'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sync_err <= 1'b0;
    else if (sample_pixel && pixel_index != idx)
      sync_err <= 1'b1;
  end

  always_comb begin
    pixel_data = BG_COLOR;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (layer_en[k] &&
          layer_pixel[16*k +: 16] != TRANSPARENT)
        pixel_data = layer_pixel[16*k +: 16];
    end
  end

endmodule

// File: tb/tb_oled_layer_sequencer.sv
// Directed bench for oled_layer_sequencer.
// Raster walk, priority, debounce, collision, mismatch, reset.
module tb_oled_layer_sequencer;

  localparam int DB = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_begin;
  logic        sample_pixel;
  logic [12:0] pixel_index;
  logic [3:0]  sw;
  logic [63:0] layer_pixel;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [15:0] pixel_data;
  logic [3:0]  layer_en;
  logic [7:0]  frame_count;
  logic        sync_err;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  oled_layer_sequencer #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_begin(frame_begin),
    .sample_pixel(sample_pixel),
    .pixel_index(pixel_index),
    .sw(sw),
    .layer_pixel(layer_pixel),
    .x(x),
    .y(y),
    .pixel_data(pixel_data),
    .layer_en(layer_en),
    .frame_count(frame_count),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fb_pulse();
    frame_begin = 1'b1;
    step();
    frame_begin = 1'b0;
  endtask

  task automatic walk(input int first, input int n);
    sample_pixel = 1'b1;
    for (int i = 0; i < n; i++) begin
      pixel_index = 13'(first + i);
      step();
    end
    sample_pixel = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    frame_begin  = 1'b0;
    sample_pixel = 1'b0;
    pixel_index  = '0;
    sw           = 4'b0101;
    layer_pixel  = {16'hFFFF, 16'h07E0,
                    16'h001F, 16'hF800};
    #3;
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);
    check("rst_err", 32'(sync_err), 32'd0);
    check("rst_en", 32'(layer_en), 32'd0);
    check("rst_pix", 32'(pixel_data), 32'h0000);
    step();
    reset = 1'b1;
    repeat (DB + 6) step();

    fb_pulse();
    check("fb1_fc", 32'(frame_count), 32'd1);
    check("fb1_en", 32'(layer_en), 32'h5);
    check("fb1_xy", {x, y}, 32'd0);

    check("pri_l2", 32'(pixel_data), 32'h07E0);
    layer_pixel[32 +: 16] = 16'h0000;
    #1;
    check("pri_l0", 32'(pixel_data), 32'hF800);
    layer_pixel[0 +: 16] = 16'h0000;
    #1;
    check("pri_bg", 32'(pixel_data), 32'h0000);

    walk(0, 96);
    check("walk_row1_x", 32'(x), 32'd0);
    check("walk_row1_y", 32'(y), 32'd1);
    walk(96, 6143 - 96);
    check("walk_end_x", 32'(x), 32'd95);
    check("walk_end_y", 32'(y), 32'd63);
    walk(6143, 1);
    check("walk_wrap", {x, y}, 32'd0);
    check("walk_err", 32'(sync_err), 32'd0);
    check("walk_fc", 32'(frame_count), 32'd1);

    walk(0, 40);
    check("col_pre_x", 32'(x), 32'd40);
    pixel_index  = 13'd40;
    sample_pixel = 1'b1;
    fb_pulse();
    sample_pixel = 1'b0;
    check("col_xy", {x, y}, 32'd0);
    check("col_fc", 32'(frame_count), 32'd2);
    check("col_err", 32'(sync_err), 32'd0);

    for (int i = 0; i < 20; i++) begin
      sw[1] = ~sw[1];
      repeat (5) step();
    end
    sw[1] = 1'b1;
    repeat (DB + 1) step();
    check("deb_early", 32'(dut.sw_deb[1]), 32'd0);
    step();
    check("deb_rise", 32'(dut.sw_deb[1]), 32'd1);
    repeat (3) step();
    check("deb_en_hold", 32'(layer_en), 32'h5);
    fb_pulse();
    check("deb_en_fb", 32'(layer_en), 32'h7);
    check("deb_fc", 32'(frame_count), 32'd3);

    walk(0, 99);
    check("mm_x", 32'(x), 32'd3);
    check("mm_y", 32'(y), 32'd1);
    check("mm_pre", 32'(sync_err), 32'd0);
    walk(100, 1);
    check("mm_set", 32'(sync_err), 32'd1);
    fb_pulse();
    check("mm_sticky", 32'(sync_err), 32'd1);
    check("mm_fc", 32'(frame_count), 32'd4);

    layer_pixel = {16'hFFFF, 16'h07E0,
                   16'h001F, 16'hF800};
    walk(0, 30 * 96 + 50);
    check("mid_x", 32'(x), 32'd50);
    check("mid_y", 32'(y), 32'd30);
    check("mid_pix", 32'(pixel_data), 32'h07E0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_x", 32'(x), 32'd0);
    check("arst_y", 32'(y), 32'd0);
    check("arst_fc", 32'(frame_count), 32'd0);
    check("arst_err", 32'(sync_err), 32'd0);
    check("arst_en", 32'(layer_en), 32'd0);
    check("arst_pix", 32'(pixel_data), 32'h0000);
    step();
    reset = 1'b1;
    check("post_en", 32'(layer_en), 32'd0);
    repeat (DB + 6) step();
    fb_pulse();
    check("re_xy", {x, y}, 32'd0);
    check("re_fc", 32'(frame_count), 32'd1);
    check("re_en", 32'(layer_en), 32'h7);
    walk(0, 1);
    check("re_x1", 32'(x), 32'd1);
    check("re_err", 32'(sync_err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/oled_layer_sequencer.md
OLED_LAYER_SEQUENCER -- requirements
Module: oled_layer_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 96, meaning display columns.
REQ-002 SHALL have parameter HEIGHT, default 64, meaning display rows.
REQ-003 SHALL have parameter NUM_LAYERS, default 4, range 1..8, meaning number of composited pixel sources.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 16, range 2..65535, meaning stable cycles required before a switch change is accepted.
REQ-005 SHALL have parameter TRANSPARENT, default 16'h0000, meaning the RGB565 key that lets lower layers show through.
REQ-006 SHALL have parameter BG_COLOR, default 16'h0000, meaning the colour shown when no enabled layer is opaque.
REQ-007 SHALL have port clk, input, 1, meaning the single pixel clock (6.25 MHz domain shared with Oled_Display).
REQ-008 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-009 SHALL have port frame_begin, input, 1, meaning the single-cycle frame start pulse from Oled_Display.
REQ-010 SHALL have port sample_pixel, input, 1, meaning the single-cycle pixel consume strobe from Oled_Display.
REQ-011 SHALL have port pixel_index, input, 13, meaning the display's current linear index, used only for checking.
REQ-012 SHALL have port sw, input, NUM_LAYERS, meaning raw, asynchronous layer-enable switches.
REQ-013 SHALL have port layer_pixel, input, 16*NUM_LAYERS, meaning layer k colour in bits [16k+15:16k], a combinational function of x/y.
REQ-014 SHALL have port x, output, 7, meaning the column of the next pixel to be sampled.
REQ-015 SHALL have port y, output, 6, meaning the row of the next pixel to be sampled.
REQ-016 SHALL have port pixel_data, output, 16, meaning the composited RGB565 value for (x, y).
REQ-017 SHALL have port layer_en, output, NUM_LAYERS, meaning the enables applied to the current frame.
REQ-018 SHALL have port frame_count, output, 8, meaning frames started since reset.
REQ-019 SHALL have port sync_err, output, 1, meaning a sticky flag for an index mismatch.

Function
REQ-020 SHALL pass each sw bit through a 2-flop synchroniser, then a per-bit debounce counter.
- The debounced bit updates only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any bounce back restarts that bit's counter.
REQ-021 SHALL copy the debounced enables into layer_en only on a cycle with frame_begin=1, so enables never change mid-frame.
REQ-022 SHALL on frame_begin set x=0, y=0, internal linear index=0, and frame_count=frame_count+1 (wrapping 255->0).
REQ-023 SHALL on sample_pixel without frame_begin advance the coordinates, and update the internal index in step without using a multiplier or divider:
- x=x+1 while x<WIDTH-1;
- at x=WIDTH-1: x=0 and y=y+1;
- at (WIDTH-1, HEIGHT-1): wrap to (0,0), index=0.
REQ-024 SHALL, when frame_begin and sample_pixel are both 1 in one cycle, apply frame_begin only.
REQ-025 SHALL on every sample_pixel compare pixel_index with the internal index and set sync_err=1 on inequality; only reset clears it.
REQ-026 SHALL drive pixel_data combinationally each cycle:
- use the highest-numbered layer k with layer_en[k]=1 and layer_pixel[k]!=TRANSPARENT;
- otherwise use BG_COLOR.
REQ-027 SHALL change x and y only on the clock edge following a frame_begin or sample_pixel.
REQ-028 SHALL hold all state when neither frame_begin nor sample_pixel is asserted, apart from the synchroniser and debounce logic.

Reset
REQ-029 SHALL on reset=0, asynchronously and at any point in a frame, force the following; debounced values take effect from the first frame_begin after release:
- x=0, y=0, internal index=0, frame_count=0, sync_err=0, layer_en=0;
- synchronisers and debounced values=0, debounce counters=0.
REQ-030 SHALL drive pixel_data=BG_COLOR during reset, because layer_en is 0.

Verification
REQ-031 SHALL cover raster walk: frame_begin, then 6144 sample_pixel pulses with matching pixel_index -> x,y reach (95,63) and wrap to (0,0); sync_err=0; frame_count=1.
REQ-032 SHALL cover priority: layer_en=4'b0101, layer0=16'hF800, layer2=16'h07E0 -> pixel_data=16'h07E0; then layer2=TRANSPARENT -> 16'hF800; then both transparent -> BG_COLOR.
REQ-033 SHALL cover debounce: sw[1] toggles every 5 cycles for 100 cycles, then holds 1 -> debounced bit rises exactly DEBOUNCE_CYCLES+2 cycles after the final edge; layer_en[1] rises only at the next frame_begin.
REQ-034 SHALL cover collision: frame_begin and sample_pixel together at x=40 -> x=0, y=0, frame_count increments once.
REQ-035 SHALL cover mismatch: pixel_index=100 while the internal index is 99 at sample_pixel -> sync_err=1 next cycle and it stays 1 through the following frame_begin.
REQ-036 SHALL cover reset mid-frame: reset=0 at (50,30) -> all outputs at reset values immediately, without waiting for a clock edge; after release, the raster restarts at (0,0) on frame_begin.
